// File: rtl/weightbuffer_load_ctrl.sv
// weightbuffer_load_ctrl: two-set weight buffer load sequencer; WEIGHTBUFFER_LOAD_CTRL_PERF_EN adds stall_cycles_o
module weightbuffer_load_ctrl #(
  parameter int N_I = 512,
  parameter int WEIGHT_STAGGER = 2,
  parameter int K = 3
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic load_start_i,
  input  logic weight_valid_i,
  input  logic [0:N_I/WEIGHT_STAGGER-1][1:0] weight_data_i,
  output logic weight_ready_o,
  input  logic swap_i,
  output logic [0:1][0:WEIGHT_STAGGER-1][0:K-1][0:K-1] save_enable_o,
  output logic [0:1][0:WEIGHT_STAGGER-1] flush_o,
  output logic [0:N_I/WEIGHT_STAGGER-1][1:0] data_o,
  output logic active_set_o,
  output logic swap_ready_o,
  output logic load_done_o,
  output logic busy_o
`ifdef WEIGHTBUFFER_LOAD_CTRL_PERF_EN
  ,
  output logic [31:0] stall_cycles_o
`endif
);
  localparam int SW = WEIGHT_STAGGER > 1 ? $clog2(WEIGHT_STAGGER) : 1;
  localparam int KW = K > 1 ? $clog2(K) : 1;
  typedef enum logic [1:0] {IDLE, FLUSH, LOAD} state_t;
  state_t state, state_nxt;
  logic [SW-1:0] s;
  logic [KW-1:0] k1, k2;
  logic loaded, inactive, hs, last, start, swap_ok, k2_end, k1_end;
  assign inactive = ~active_set_o;
  assign hs = state == LOAD && weight_valid_i;
  assign k2_end = k2 == KW'(K-1);
  assign k1_end = k1 == KW'(K-1);
  assign last = s == SW'(WEIGHT_STAGGER-1) && k1_end && k2_end;
  assign start = state == IDLE && load_start_i;
  assign swap_ok = swap_i && swap_ready_o;
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) state <= IDLE;
    else state <= state_nxt;
  always_comb
    state_nxt = start ? FLUSH : state == FLUSH ? LOAD : hs && last ? IDLE : state;
  always_comb begin
    weight_ready_o = state == LOAD;
    busy_o = state != IDLE;
    swap_ready_o = loaded && state == IDLE;
    flush_o = '0;
    if (state == FLUSH) flush_o[inactive] = '1;
  end
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      active_set_o <= 1'b0;
      loaded <= 1'b0;
      s <= '0;
      k1 <= '0;
      k2 <= '0;
      save_enable_o <= '0;
      data_o <= '0;
      load_done_o <= 1'b0;
    end else begin
      save_enable_o <= '0;
      load_done_o <= hs && last;
      if (swap_ok) active_set_o <= ~active_set_o;
      if (swap_ok || start) loaded <= 1'b0;
      else if (hs && last) loaded <= 1'b1;
      if (start) begin
        s <= '0;
        k1 <= '0;
        k2 <= '0;
      end else if (hs) begin
        save_enable_o[inactive][s][k1][k2] <= 1'b1;
        data_o <= weight_data_i;
        k2 <= k2_end ? '0 : k2 + 1'b1;
        k1 <= !k2_end ? k1 : k1_end ? '0 : k1 + 1'b1;
        s <= !(k2_end && k1_end) ? s : last ? '0 : s + 1'b1;
      end
    end
`ifdef WEIGHTBUFFER_LOAD_CTRL_PERF_EN
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) stall_cycles_o <= '0;
    else if (start) stall_cycles_o <= '0;
    else if (state == LOAD && !weight_valid_i) stall_cycles_o <= stall_cycles_o + 32'd1;
`endif
endmodule

// File: tb/tb_weightbuffer_load_ctrl.sv
// tb_weightbuffer_load_ctrl: randomized bench against a word-count reference model
module tb_weightbuffer_load_ctrl;
  localparam int NI = 512, WS = 2, KK = 3, W = WS*KK*KK;
  logic clk = 1'b0, rst_ni;
  logic load_start_i, weight_valid_i, swap_i;
  logic [511:0] weight_data_i, data_o;
  logic weight_ready_o, active_set_o, swap_ready_o, load_done_o, busy_o;
  logic [0:1][0:WS-1][0:KK-1][0:KK-1] save_enable_o;
  logic [0:1][0:WS-1] flush_o;
`ifdef WEIGHTBUFFER_LOAD_CTRL_PERF_EN
  logic [31:0] stall_cycles_o;
`endif
  int tests = 0, fails = 0;
  int m_cnt;
  bit m_active, m_loaded, m_done;
  logic [35:0] m_se;
  logic [3:0] m_flush;
  logic [511:0] m_data;
  int unsigned m_stall;

  weightbuffer_load_ctrl #(.N_I(NI), .WEIGHT_STAGGER(WS), .K(KK)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .load_start_i(load_start_i),
    .weight_valid_i(weight_valid_i), .weight_data_i(weight_data_i),
    .weight_ready_o(weight_ready_o), .swap_i(swap_i), .save_enable_o(save_enable_o),
    .flush_o(flush_o), .data_o(data_o), .active_set_o(active_set_o),
    .swap_ready_o(swap_ready_o), .load_done_o(load_done_o), .busy_o(busy_o)
`ifdef WEIGHTBUFFER_LOAD_CTRL_PERF_EN
    , .stall_cycles_o(stall_cycles_o)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(string tag, logic [511:0] got, logic [511:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (low 128 bits)", tag, got[127:0], exp[127:0]);
    end
  endtask

  function automatic logic [511:0] rnd_word();
    logic [511:0] w;
    for (int j = 0; j < 16; j++) w[j*32 +: 32] = $urandom;
    return w;
  endfunction

  task automatic model_reset();
    m_cnt = -2; m_active = 0; m_loaded = 0; m_done = 0;
    m_se = '0; m_flush = '0; m_data = '0; m_stall = 0;
  endtask

  // m_cnt: -2 idle, -1 flushing, 0..W-1 index of the next word to be written
  task automatic model_step();
    bit hs, swap_ok, start;
    int set;
    hs = m_cnt >= 0 && weight_valid_i;
    swap_ok = swap_i && m_loaded && m_cnt == -2;
    start = m_cnt == -2 && load_start_i;
    m_se = '0; m_flush = '0; m_done = 0;
    if (m_cnt >= 0 && !weight_valid_i) m_stall++;
    if (swap_ok) begin m_active = !m_active; m_loaded = 0; end
    if (start) begin m_loaded = 0; m_cnt = -1; m_stall = 0; end
    else if (m_cnt == -1) m_cnt = 0;
    else if (hs) begin
      set = m_active ? 0 : 1;
      m_se = 36'd1 << (35 - (((set*WS + m_cnt/(KK*KK))*KK + (m_cnt%(KK*KK))/KK)*KK + m_cnt%KK));
      m_data = weight_data_i;
      if (m_cnt == W-1) begin m_cnt = -2; m_loaded = 1; m_done = 1; end
      else m_cnt++;
    end
    if (m_cnt == -1) m_flush = m_active ? 4'b1100 : 4'b0011;
  endtask

  task automatic compare_all();
    check("active_set", active_set_o, m_active);
    check("weight_ready", weight_ready_o, m_cnt >= 0);
    check("busy", busy_o, m_cnt >= -1);
    check("swap_ready", swap_ready_o, m_loaded && m_cnt == -2);
    check("load_done", load_done_o, m_done);
    check("flush", flush_o, m_flush);
    check("save_enable", save_enable_o, m_se);
    check("data", data_o, m_data);
`ifdef WEIGHTBUFFER_LOAD_CTRL_PERF_EN
    check("stall_cycles", stall_cycles_o, m_stall);
`endif
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic drv(bit ls, bit v, bit sw, logic [511:0] d);
    load_start_i = ls; weight_valid_i = v; swap_i = sw; weight_data_i = d;
  endtask

  task automatic run_load(int gap_at, int gap_len, int stop, bit seq, bit sw);
    int n = 0, g = 0;
    drv(1, 0, sw, rnd_word()); cycle();
    drv(0, 0, 0, rnd_word()); cycle();
    for (int t = 0; t < 200 && n < stop; t++) begin
      if (n == gap_at && g < gap_len) begin
        drv(t % 3 == 0, 0, t % 2 == 1, rnd_word());
        g++;
      end else begin
        drv(0, 1, 0, seq ? 512'(n) : rnd_word());
        n++;
      end
      cycle();
    end
    drv(0, 0, 0, rnd_word());
  endtask

  initial begin
    rst_ni = 1'b0;
    drv(0, 0, 0, '0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    compare_all();
    rst_ni = 1'b1;
    drv(0, 0, 1, rnd_word()); cycle();
    drv(0, 0, 0, rnd_word()); cycle();
    run_load(-1, 0, W, 1, 0);
    check("swap_ready_after_20", swap_ready_o, 1'b1);
    cycle(); cycle();
    drv(0, 0, 1, rnd_word()); cycle();
    check("active_after_swap", active_set_o, 1'b1);
    drv(0, 0, 0, rnd_word()); cycle();
    run_load(6, 5, W, 0, 0);
    cycle();
`ifdef WEIGHTBUFFER_LOAD_CTRL_PERF_EN
    check("stall_gap5", stall_cycles_o, 32'd5);
`endif
    run_load(-1, 0, 11, 0, 0);
    cycle();
    rst_ni = 1'b0;
    #1;
    model_reset();
    compare_all();
    rst_ni = 1'b1;
    repeat (3) begin drv(0, 0, 1, rnd_word()); cycle(); end
    drv(0, 0, 0, rnd_word()); cycle();
    run_load(-1, 0, W, 0, 0);
    cycle();
    run_load(-1, 0, W, 0, 1);
    cycle();
    for (int t = 0; t < 400; t++) begin
      drv($urandom_range(9) == 0, $urandom_range(9) < 7, $urandom_range(9) == 0, rnd_word());
      cycle();
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end
endmodule
